mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Memory-access and write-back stage of the pipelined ARM core. Takes the EXE/MEM-registered instruction, runs loads and stores against an external data SRAM through a req/ack handshake, and freezes upstream stages while an access is outstanding. It produces the registered write-back triple (WB_WB_EN, WB_Dest, WB_Value) consumed by the decode stage's register file.

## Interface
Parameters:
- BASE, 1024, byte offset subtracted from the ALU result to form the memory address.
- TIMEOUT, 15, maximum ACCESS cycles without mem_ack before the access is aborted.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ex_valid  in  1  instruction present in EXE/MEM register.
- ex_wb_en  in  1  instruction writes a register.
- ex_mem_r_en  in  1  load.
- ex_mem_w_en  in  1  store; never asserted together with ex_mem_r_en.
- ex_dest  in  4  destination register.
- ex_alu_res  in  32  ALU result (address for memory operations).
- ex_st_val  in  32  store data.
- mem_req  out  1  access request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  30  word address: (ex_alu_res − BASE)[31:2].
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data; valid in the cycle mem_ack is high.
- mem_ack  in  1  one-cycle completion pulse.
- freeze  out  1  hold IF/ID/EXE and their pipeline registers.
- mem_err  out  1  sticky timeout flag.
- WB_WB_EN  out  1  register-file write enable (registered).
- WB_Dest  out  4  write register (registered).
- WB_Value  out  32  write data (registered).

## Operation
- A memory op is `ex_valid & (ex_mem_r_en | ex_mem_w_en)`.
- FSM states are IDLE, ACCESS and DONE.
- IDLE, memory op:
  - latch mem_addr, mem_wdata, mem_we, ex_dest and ex_wb_en;
  - clear the timeout counter;
  - freeze=1 combinationally;
  - go to ACCESS;
  - the WB registers load a bubble (WB_WB_EN=0).
- IDLE, non-memory op:
  - the WB registers load ex_wb_en&ex_valid, ex_dest and ex_alu_res;
  - freeze=0;
  - stay in IDLE.
- ACCESS:
  - mem_req=1 and freeze=1;
  - the counter increments each cycle without an ack;
  - on mem_ack: capture mem_rdata into the load buffer and go to DONE;
  - if the counter reaches TIMEOUT−1 without an ack: set mem_err, load the buffer with 0, go to DONE;
  - the WB registers load a bubble.
- DONE:
  - mem_req=0 and freeze=0;
  - the WB registers load the latched wb_en/dest and the buffer (store: WB_WB_EN=0);
  - ex_* still shows the same instruction this cycle and is ignored;
  - go to IDLE.
  - Upstream advances at the end of this cycle.
- mem_ack outside ACCESS is ignored.
- ex_* is not sampled in ACCESS or DONE.
- mem_err is cleared only by reset.

## Timing
- Reset (async, rst low) forces:
  - state IDLE and counter 0;
  - mem_req, mem_we, mem_addr, mem_wdata = 0;
  - freeze, mem_err = 0;
  - WB_WB_EN, WB_Dest, WB_Value = 0.
- mem_req drops within the reset assertion, including mid-ACCESS.
- Non-memory op: presented in cycle N, WB valid in N+1.
- Memory op: presented in cycle N; ACCESS starts at N+1; ack in cycle N+k (k≥1); DONE at N+k+1; WB valid in N+k+2.
- freeze is high in cycles N through N+k.
- Minimum freeze is 2 cycles, with ack in the first ACCESS cycle.
- Timeout: ACCESS lasts exactly TIMEOUT cycles and mem_err rises in the cycle after the last ACCESS cycle.
- mem_req and mem_we stay constant throughout ACCESS.
- mem_addr and mem_wdata come from the IDLE latch, so they are stable from N+1 until the next op is latched.
- Address arithmetic is 32-bit unsigned with wrap-around; ex_alu_res < BASE wraps and is not an error.

## Structure
- Shared package (cpu_pkg):
  - state enum {IDLE, ACCESS, DONE};
  - BASE default;
  - WB bundle typedef {wb_en, dest[3:0], value[31:0]}.
- One natural sub-module: mem_handshake (the FSM, timeout counter and load buffer).
- The WB output register and the input latch stay in the top module.

## Test plan
- ADD result 0x0000_0042, dest 5, wb_en=1, no memory op → next cycle WB_WB_EN=1, WB_Dest=5, WB_Value=0x42; freeze never asserted.
- LDR with ex_alu_res=1024+0x10, dest 3; ack on the 3rd ACCESS cycle with rdata=0xDEAD_BEEF:
  - mem_addr=4, mem_we=0;
  - freeze high for 4 cycles;
  - WB_Value=0xDEAD_BEEF, WB_Dest=3 two cycles after the ack.
- STR with ex_alu_res=1028, ex_st_val=0x1234, ack on the 1st ACCESS cycle:
  - mem_we=1, mem_addr=1, mem_wdata=0x1234;
  - freeze high for 2 cycles;
  - WB_WB_EN stays 0.
- LDR with no ack (TIMEOUT=15):
  - mem_req high for exactly 15 cycles;
  - then mem_err=1 and WB_Value=0 with WB_WB_EN=1;
  - mem_err stays set through later instructions.
- Reset pulled low on the 2nd ACCESS cycle → mem_req, freeze and WB outputs go to 0 immediately; after release the first non-memory op completes normally.
- Back-to-back LDR then ADD:
  - the ADD is not launched as a memory op;
  - the ADD's WB appears exactly one cycle after the LDR's WB;
  - a stray mem_ack in IDLE has no effect.

Source files
------------

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Shared types and defaults for the memory-access / write-back stage.
//   - state_t    : handshake FSM states (IDLE, ACCESS, DONE)
//   - wb_t       : registered write-back bundle {wb_en, dest, value}
//   - BASE_DEFAULT / TIMEOUT_DEFAULT : default stage parameters
//   - word_addr(): byte ALU result -> 30-bit SRAM word address
// ---------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int unsigned BASE_DEFAULT    = 1024;
  localparam int unsigned TIMEOUT_DEFAULT = 15;

  typedef struct packed {
    logic        wb_en;
    logic [3:0]  dest;
    logic [31:0] value;
  } wb_t;

  // All-zero bundle: a pipeline bubble that writes nothing.
  localparam wb_t WB_BUBBLE = '0;

  // Subtraction wraps modulo 2^32, so results below base are legal and
  // simply map to the top of the word-address space.
  function automatic logic [29:0] word_addr(input logic [31:0] alu_res,
                                            input logic [31:0] base);
    return 30'((alu_res - base) >> 2);
  endfunction

endpackage : cpu_pkg

// File: rtl/mem_wb_stage_if.sv
// ---------------------------------------------------------------------------
// mem_wb_stage_if
//   Data-SRAM request/acknowledge bus between the MEM/WB stage (master) and
//   the memory (slave).
//
//   Handshake: the master holds mem_req high, together with a stable mem_we,
//   mem_addr and mem_wdata, for as long as one access is outstanding. The
//   slave completes the access by pulsing mem_ack for exactly one cycle;
//   for reads mem_rdata is valid only in that cycle. The master drops
//   mem_req in the cycle after the ack, and any mem_ack seen while mem_req
//   is low is ignored.
//
//   Signals:
//     mem_req   master->slave  access request
//     mem_we    master->slave  1 = write, 0 = read
//     mem_addr  master->slave  30-bit word address
//     mem_wdata master->slave  store data
//     mem_rdata slave->master  load data (valid with mem_ack)
//     mem_ack   slave->master  one-cycle completion pulse
// ---------------------------------------------------------------------------
interface mem_wb_stage_if;

  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );

endinterface : mem_wb_stage_if

// File: rtl/mem_handshake.sv
// ---------------------------------------------------------------------------
// mem_handshake
//   Access sequencer for the MEM/WB stage: IDLE -> ACCESS -> DONE -> IDLE.
//   Owns the timeout counter, the load buffer and the sticky error flag.
//
//   Ports:
//     clk         in   clock
//     rst         in   asynchronous active-low reset
//     mem_op_i    in   a valid load/store is presented by EXE/MEM
//     mem_ack_i   in   one-cycle SRAM completion pulse
//     mem_rdata_i in   SRAM read data (valid with mem_ack_i)
//     state_o     out  current FSM state (debug / observation)
//     mem_req_o   out  access request, high throughout ACCESS
//     freeze_o    out  stall upstream stages
//     latch_o     out  capture the memory operation this cycle
//     done_o      out  write back the completed memory operation this cycle
//     mem_err_o   out  sticky timeout flag, cleared only by reset
//     load_buf_o  out  captured read data (0 after a timeout)
// ---------------------------------------------------------------------------
module mem_handshake
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_op_i,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output state_t      state_o,
  output logic        mem_req_o,
  output logic        freeze_o,
  output logic        latch_o,
  output logic        done_o,
  output logic        mem_err_o,
  output logic [31:0] load_buf_o
);

  // Counter only needs to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       buf_q, buf_d;
  logic              err_q, err_d;
  logic              freeze_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    err_d     = err_q;
    mem_req_o = 1'b0;
    freeze_c  = 1'b0;
    latch_o   = 1'b0;
    done_o    = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_op_i) begin
          // Freeze already in the launch cycle so the EXE/MEM register holds
          // the instruction until its write-back is issued from DONE.
          latch_o  = 1'b1;
          freeze_c = 1'b1;
          cnt_d    = '0;
          state_d  = ACCESS;
        end
      end

      ACCESS: begin
        mem_req_o = 1'b1;
        freeze_c  = 1'b1;
        if (mem_ack_i) begin
          buf_d   = mem_rdata_i;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          // Abandon the access after TIMEOUT silent cycles; the load
          // returns zero and the error is remembered until reset.
          err_d   = 1'b1;
          buf_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        // Upstream is released this cycle; ex_* still shows the finished
        // instruction and must not relaunch it.
        done_o  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // freeze is partly combinational from ex_*; hold it low while reset is
  // asserted so a frozen upstream is released immediately.
  assign freeze_o   = freeze_c & rst;
  assign state_o    = state_q;
  assign mem_err_o  = err_q;
  assign load_buf_o = buf_q;

endmodule : mem_handshake

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//   Memory-access and write-back stage. Non-memory instructions pass straight
//   to the registered write-back outputs; loads and stores are latched,
//   issued to the data SRAM over a req/ack bus, and written back once the
//   access completes or times out. Upstream stages are frozen meanwhile.
//
//   Ports:
//     clk, rst      clock, asynchronous active-low reset
//     ex_valid      instruction present in EXE/MEM register
//     ex_wb_en      instruction writes a register
//     ex_mem_r_en   load
//     ex_mem_w_en   store (never together with ex_mem_r_en)
//     ex_dest       destination register
//     ex_alu_res    ALU result / byte address
//     ex_st_val     store data
//     mem           data-SRAM bus (master side)
//     freeze        hold IF/ID/EXE and their pipeline registers
//     mem_err       sticky timeout flag
//     WB_WB_EN, WB_Dest, WB_Value   registered write-back triple
//     dbg_state_o   handshake FSM state for observation
// ---------------------------------------------------------------------------
module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter int unsigned BASE    = BASE_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ex_valid,
  input  logic                   ex_wb_en,
  input  logic                   ex_mem_r_en,
  input  logic                   ex_mem_w_en,
  input  logic [3:0]             ex_dest,
  input  logic [31:0]            ex_alu_res,
  input  logic [31:0]            ex_st_val,
  mem_wb_stage_if.master         mem,
  output logic                   freeze,
  output logic                   mem_err,
  output logic                   WB_WB_EN,
  output logic [3:0]             WB_Dest,
  output logic [31:0]            WB_Value,
  output state_t                 dbg_state_o
);

  logic        mem_op;
  state_t      state;
  logic        mem_req;
  logic        latch;
  logic        done;
  logic [31:0] load_buf;

  // Operation latched at launch; drives the SRAM bus for the whole access
  // and supplies the write-back destination afterwards.
  logic [29:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q,    we_d;
  logic [3:0]  dest_q,  dest_d;
  logic        wb_en_q, wb_en_d;

  wb_t         wb_q, wb_d;

  assign mem_op = ex_valid & (ex_mem_r_en | ex_mem_w_en);

  mem_handshake #(
    .TIMEOUT (TIMEOUT)
  ) u_handshake (
    .clk         (clk),
    .rst         (rst),
    .mem_op_i    (mem_op),
    .mem_ack_i   (mem.mem_ack),
    .mem_rdata_i (mem.mem_rdata),
    .state_o     (state),
    .mem_req_o   (mem_req),
    .freeze_o    (freeze),
    .latch_o     (latch),
    .done_o      (done),
    .mem_err_o   (mem_err),
    .load_buf_o  (load_buf)
  );

  // Input latch.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    dest_d  = dest_q;
    wb_en_d = wb_en_q;
    if (latch) begin
      addr_d  = word_addr(ex_alu_res, 32'(BASE));
      wdata_d = ex_st_val;
      we_d    = ex_mem_w_en;
      dest_d  = ex_dest;
      // A store never writes the register file, whatever ex_wb_en says.
      wb_en_d = ex_wb_en & ~ex_mem_w_en;
    end
  end

  // Write-back source: pass-through in IDLE, completed access in DONE,
  // bubble while an access is being launched or is outstanding.
  always_comb begin
    wb_d = WB_BUBBLE;
    if (done) begin
      wb_d.wb_en = wb_en_q;
      wb_d.dest  = dest_q;
      wb_d.value = load_buf;
    end else if ((state == IDLE) && !mem_op) begin
      wb_d.wb_en = ex_wb_en & ex_valid;
      wb_d.dest  = ex_dest;
      wb_d.value = ex_alu_res;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      dest_q  <= '0;
      wb_en_q <= 1'b0;
      wb_q    <= WB_BUBBLE;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      dest_q  <= dest_d;
      wb_en_q <= wb_en_d;
      wb_q    <= wb_d;
    end
  end

  assign mem.mem_req   = mem_req;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  assign WB_WB_EN    = wb_q.wb_en;
  assign WB_Dest     = wb_q.dest;
  assign WB_Value    = wb_q.value;
  assign dbg_state_o = state;

endmodule : mem_wb_stage

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage
//   Self-checking bench for mem_wb_stage: directed scenarios followed by
//   randomized instruction streams, compared against a transaction-level
//   model of the stage's timing and write-back results.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage;
  import cpu_pkg::*;

  localparam int unsigned BASE    = 1024;
  localparam int unsigned TIMEOUT = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic        ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en;
  logic [3:0]  ex_dest;
  logic [31:0] ex_alu_res, ex_st_val;
  logic        freeze, mem_err, WB_WB_EN;
  logic [3:0]  WB_Dest;
  logic [31:0] WB_Value;
  state_t      dbg_state;

  mem_wb_stage_if mem ();

  mem_wb_stage #(
    .BASE    (BASE),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst_n),
    .ex_valid    (ex_valid),
    .ex_wb_en    (ex_wb_en),
    .ex_mem_r_en (ex_mem_r_en),
    .ex_mem_w_en (ex_mem_w_en),
    .ex_dest     (ex_dest),
    .ex_alu_res  (ex_alu_res),
    .ex_st_val   (ex_st_val),
    .mem         (mem),
    .freeze      (freeze),
    .mem_err     (mem_err),
    .WB_WB_EN    (WB_WB_EN),
    .WB_Dest     (WB_Dest),
    .WB_Value    (WB_Value),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  // Entry: {check_all, wb_en, dest[3:0], value[31:0]}; check_all=0 means
  // only wb_en is defined (stores).
  logic [37:0] exp_q[$];
  logic        err_exp;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference: kind 0 = non-memory, 1 = load, 2 = store.
  function automatic logic [37:0] predict(input int kind, input logic valid,
      input logic wb_en, input logic [3:0] dest, input logic [31:0] alu,
      input bit acked, input logic [31:0] rdata);
    case (kind)
      0:       return {1'b1, valid & wb_en, dest, alu};
      1:       return {1'b1, wb_en, dest, (acked ? rdata : 32'h0)};
      default: return {1'b0, 1'b0, dest, 32'h0};
    endcase
  endfunction

  task automatic check_wb(input string tag);
    logic [37:0] e;
    check({tag, "_qsize"}, 64'(exp_q.size()), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_wb_en"}, WB_WB_EN, e[36]);
      if (e[37]) begin
        check({tag, "_wb_dest"},  WB_Dest,  e[35:32]);
        check({tag, "_wb_value"}, WB_Value, e[31:0]);
      end
    end
    check({tag, "_mem_err"}, mem_err, err_exp);
  endtask

  // ---------------- drivers ----------------
  // Each task starts 1 time unit after a rising edge (cycle N) and returns
  // 1 time unit after the edge on which its write-back becomes visible.
  task automatic do_alu(input string tag, input logic valid, input logic wb_en,
                        input logic [3:0] dest, input logic [31:0] alu,
                        input logic stray_ack);
    ex_valid    = valid;
    ex_wb_en    = wb_en;
    // An invalid slot carrying a stale load flag must not start an access.
    ex_mem_r_en = valid ? 1'b0 : 1'($urandom_range(0, 1));
    ex_mem_w_en = 1'b0;
    ex_dest     = dest;
    ex_alu_res  = alu;
    ex_st_val   = $urandom;
    mem.mem_ack   = stray_ack;
    mem.mem_rdata = $urandom;
    #1;
    check({tag, "_freeze"}, freeze, 1'b0);
    check({tag, "_req"}, mem.mem_req, 1'b0);
    exp_q.push_back(predict(0, valid, wb_en, dest, alu, 1'b0, 32'h0));
    @(posedge clk); #1;
    mem.mem_ack = 1'b0;
    check_wb(tag);
  endtask

  // k = ACCESS cycle carrying the ack; k > TIMEOUT means no ack at all.
  task automatic do_mem(input string tag, input logic is_store,
                        input logic wb_en, input logic [3:0] dest,
                        input logic [31:0] alu, input logic [31:0] st,
                        input int k, input logic [31:0] rdata,
                        input logic stray_done);
    logic [31:0] off;
    logic [29:0] exp_addr;
    bit          acked;
    off      = alu - 32'(BASE);
    exp_addr = off[31:2];
    acked    = 1'b0;
    ex_valid    = 1'b1;
    ex_wb_en    = wb_en;
    ex_mem_r_en = ~is_store;
    ex_mem_w_en = is_store;
    ex_dest     = dest;
    ex_alu_res  = alu;
    ex_st_val   = st;
    mem.mem_ack   = 1'b0;
    mem.mem_rdata = $urandom;
    #1;
    check({tag, "_freeze_launch"}, freeze, 1'b1);
    check({tag, "_req_launch"}, mem.mem_req, 1'b0);
    for (int i = 1; i <= int'(TIMEOUT); i++) begin
      @(posedge clk); #1;
      check({tag, "_bubble_acc"}, WB_WB_EN, 1'b0);
      mem.mem_ack   = (i == k);
      mem.mem_rdata = (i == k) ? rdata : $urandom;
      #1;
      check({tag, "_req_acc"}, mem.mem_req, 1'b1);
      check({tag, "_freeze_acc"}, freeze, 1'b1);
      check({tag, "_we"}, mem.mem_we, is_store);
      check({tag, "_addr"}, mem.mem_addr, exp_addr);
      check({tag, "_wdata"}, mem.mem_wdata, st);
      if (i == k) begin
        acked = 1'b1;
        break;
      end
    end
    if (!acked) err_exp = 1'b1;
    exp_q.push_back(predict(is_store ? 2 : 1, 1'b1, wb_en, dest, alu,
                            acked, rdata));
    // DONE cycle
    @(posedge clk); #1;
    check({tag, "_bubble_done"}, WB_WB_EN, 1'b0);
    check({tag, "_err_done"}, mem_err, err_exp);
    mem.mem_ack   = stray_done;
    mem.mem_rdata = $urandom;
    #1;
    check({tag, "_req_done"}, mem.mem_req, 1'b0);
    check({tag, "_freeze_done"}, freeze, 1'b0);
    @(posedge clk); #1;
    mem.mem_ack = 1'b0;
    check_wb(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int kind;
    int k;
    rst_n = 1'b0;
    ex_valid = 1'b0; ex_wb_en = 1'b0; ex_mem_r_en = 1'b0; ex_mem_w_en = 1'b0;
    ex_dest = 4'h0; ex_alu_res = 32'h0; ex_st_val = 32'h0;
    mem.mem_ack = 1'b0; mem.mem_rdata = 32'h0;
    err_exp = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req",    mem.mem_req,   1'b0);
    check("rst_we",     mem.mem_we,    1'b0);
    check("rst_addr",   mem.mem_addr,  30'h0);
    check("rst_wdata",  mem.mem_wdata, 32'h0);
    check("rst_freeze", freeze,        1'b0);
    check("rst_err",    mem_err,       1'b0);
    check("rst_wb_en",  WB_WB_EN,      1'b0);
    check("rst_dest",   WB_Dest,       4'h0);
    check("rst_value",  WB_Value,      32'h0);
    check("rst_state",  dbg_state,     IDLE);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed scenarios
    do_alu("add", 1'b1, 1'b1, 4'd5, 32'h0000_0042, 1'b0);
    do_mem("ldr", 1'b0, 1'b1, 4'd3, 32'd1024 + 32'h10, 32'h0, 3,
           32'hDEAD_BEEF, 1'b0);
    do_mem("str", 1'b1, 1'b0, 4'd2, 32'd1028, 32'h0000_1234, 1,
           32'hCAFE_0000, 1'b0);
    do_mem("ldr_wrap", 1'b0, 1'b1, 4'd8, 32'h0000_0004, 32'h0, 1,
           32'h0BAD_F00D, 1'b0);
    do_mem("b2b_ldr", 1'b0, 1'b1, 4'd6, 32'd1024 + 32'h40, 32'h0, 2,
           32'h1111_2222, 1'b1);
    do_alu("b2b_add", 1'b1, 1'b1, 4'd7, 32'h0000_0099, 1'b1);
    do_mem("ldr_tmo", 1'b0, 1'b1, 4'd4, 32'd1024 + 32'h80, 32'h0,
           int'(TIMEOUT) + 5, 32'hFFFF_FFFF, 1'b0);
    do_alu("post_tmo", 1'b1, 1'b1, 4'd1, 32'h0000_0077, 1'b0);

    // Reset asserted on the second ACCESS cycle of a load
    ex_valid = 1'b1; ex_wb_en = 1'b1; ex_mem_r_en = 1'b1; ex_mem_w_en = 1'b0;
    ex_dest = 4'd7; ex_alu_res = 32'h0000_0800; ex_st_val = 32'h5555_AAAA;
    mem.mem_ack = 1'b0;
    #1;
    check("mid_rst_freeze_launch", freeze, 1'b1);
    @(posedge clk); #1;
    check("mid_rst_req_acc1", mem.mem_req, 1'b1);
    check("mid_rst_err_before", mem_err, err_exp);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req",    mem.mem_req,  1'b0);
    check("mid_rst_freeze", freeze,       1'b0);
    check("mid_rst_wb_en",  WB_WB_EN,     1'b0);
    check("mid_rst_dest",   WB_Dest,      4'h0);
    check("mid_rst_value",  WB_Value,     32'h0);
    check("mid_rst_err",    mem_err,      1'b0);
    check("mid_rst_addr",   mem.mem_addr, 30'h0);
    err_exp = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_alu("post_rst", 1'b1, 1'b1, 4'd9, 32'h1234_5678, 1'b0);

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      if (kind < 4) begin
        do_alu("rnd_alu", 1'($urandom_range(0, 5) != 0),
               1'($urandom_range(0, 1)), 4'($urandom), $urandom,
               1'($urandom_range(0, 1)));
      end else begin
        k = ($urandom_range(0, 9) == 0) ? int'(TIMEOUT) + 1
                                        : $urandom_range(1, 5);
        do_mem(kind >= 7 ? "rnd_str" : "rnd_ldr", 1'(kind >= 7),
               1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom,
               k, $urandom, 1'($urandom_range(0, 1)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mem_wb_stage
